// File: rtl/pong_link_pkg.sv
// Shared paddle-link frame definitions, used by both the transmitter and the peer receiver.
package pong_link_pkg;

    localparam logic [7:0] LINK_SYNC        = 8'hA5;
    localparam int         LINK_FRAME_BYTES = 4;

    // Byte positions within a frame
    localparam logic [1:0] LINK_IDX_SYNC = 2'd0;
    localparam logic [1:0] LINK_IDX_CTRL = 2'd1;
    localparam logic [1:0] LINK_IDX_YLO  = 2'd2;
    localparam logic [1:0] LINK_IDX_CHK  = 2'd3;

    typedef struct packed {
        logic [11:0] ypos;
        logic        button;
        logic        start;
    } link_sample_t;

    // CTRL = {2'b00, start, button, ypos[11:8]}, YLO = ypos[7:0], CHK = CTRL ^ YLO
    function automatic logic [7:0] link_byte(input logic [1:0] idx, input link_sample_t s);
        logic [7:0] ctrl;
        logic [7:0] ylo;
        ctrl = {2'b00, s.start, s.button, s.ypos[11:8]};
        ylo  = s.ypos[7:0];
        case (idx)
            LINK_IDX_SYNC: link_byte = LINK_SYNC;
            LINK_IDX_CTRL: link_byte = ctrl;
            LINK_IDX_YLO:  link_byte = ylo;
            default:       link_byte = ctrl ^ ylo;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 and pulses tick on the last count; clear holds it at 0.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/paddle_link_tx.sv
// Sends the local paddle state to the peer board as a 4-byte 8N1 UART frame.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line idle high, waiting for send
// S_START | start bit (0) of current byte
// S_DATA  | data bit bit_idx of current byte, LSB first
// S_STOP  | stop bit (1) of current byte
// S_DONE  | one-cycle frame_done, new send may be accepted
module paddle_link_tx #(
    parameter int CLK_HZ = 65000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ypos,
    input  logic        button,
    input  logic        start,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    import pong_link_pkg::*;

    localparam int DIV = CLK_HZ / BAUD;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] LAST_BYTE = 2'(LINK_FRAME_BYTES - 1);

    logic [2:0]   state;
    logic [2:0]   bit_idx;
    logic [1:0]   byte_idx;
    link_sample_t sample;
    logic         tick;
    logic         accept;
    logic [7:0]   cur_byte;

    assign busy       = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    assign frame_done = (state == S_DONE);
    assign accept     = send && !busy;
    assign cur_byte   = link_byte(byte_idx, sample);

    // Divider is held at 0 whenever no frame is in flight, so the first bit is a full period
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (!busy),
        .tick  (tick)
    );

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_idx];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            bit_idx  <= '0;
            byte_idx <= '0;
            sample   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        sample   <= {ypos, button, start};
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        state    <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (byte_idx == LAST_BYTE) begin
                            state <= S_DONE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_START;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_link_tx.sv
// Randomised scoreboard bench for paddle_link_tx with a line-level receiver monitor.
module tb_paddle_link_tx;

    localparam int CLK_HZ     = 1000000;
    localparam int BAUD       = 100000;
    localparam int DIV        = 10;
    localparam int FRAME_CLKS = 40 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ypos = '0;
    logic        button = 1'b0;
    logic        start = 1'b0;
    logic        send = 1'b0;
    logic        tx;
    logic        busy;
    logic        frame_done;

    paddle_link_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ypos       (ypos),
        .button     (button),
        .start      (start),
        .send       (send),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int next_free = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference frame from the byte-layout rules, using plain arithmetic
    function automatic logic [31:0] model_frame(input logic [11:0] y, input logic b, input logic s);
        int b1, b2, b3;
        b1 = 32 * int'(s) + 16 * int'(b) + int'(y) / 256;
        b2 = int'(y) % 256;
        b3 = b1 ^ b2;
        return {8'hA5, b1[7:0], b2[7:0], b3[7:0]};
    endfunction

    // Called at a negedge; the request is sampled at the following posedge
    task automatic pulse_send(input logic [11:0] y, input logic b, input logic s);
        ypos   = y;
        button = b;
        start  = s;
        send   = 1'b1;
        if (edge_cnt + 1 >= next_free) begin
            exp_q.push_back(model_frame(y, b, s));
            next_free = edge_cnt + 1 + FRAME_CLKS + 1;
        end
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic rand_inputs();
        ypos   = 12'($urandom);
        button = 1'($urandom);
        start  = 1'($urandom);
    endtask

    task automatic wait_free(input bit noisy);
        while (edge_cnt + 1 < next_free) begin
            if (noisy) rand_inputs();
            if (noisy && $urandom_range(0, 63) == 0)
                pulse_send(12'($urandom), 1'($urandom), 1'($urandom));
            else
                @(negedge clk);
        end
    endtask

    task automatic monitor_frame();
        logic [7:0]  rx [4];
        logic        bitv;
        bit          aborted;
        int          pos, by;
        aborted = 0;
        bitv = 1'b0;
        for (int n = 0; n < FRAME_CLKS; n++) begin
            if (n > 0) @(negedge clk);
            if (!rst) begin
                aborted = 1;
                break;
            end
            if (n % DIV == 0) begin
                bitv = tx;
                pos  = (n / DIV) % 10;
                by   = n / (DIV * 10);
                check("busy_in_frame", {31'b0, busy}, 32'd1);
                if (pos == 0)      check("start_bit", {31'b0, tx}, 32'd0);
                else if (pos == 9) check("stop_bit", {31'b0, tx}, 32'd1);
                else               rx[by][pos-1] = tx;
            end else begin
                check("bit_hold", {30'b0, tx, busy}, {30'b0, bitv, 1'b1});
            end
        end
        if (!aborted) begin
            @(negedge clk);
            if (rst) begin
                check("frame_done_at_400", {29'b0, frame_done, busy, tx}, 32'b101);
                check("rx_sync", {24'b0, rx[0]}, 32'hA5);
                check("rx_checksum", {24'b0, rx[3]}, {24'b0, rx[1] ^ rx[2]});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%h required=none", {rx[0], rx[1], rx[2], rx[3]});
                end else begin
                    check("frame_bytes", {rx[0], rx[1], rx[2], rx[3]}, exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) monitor_frame();
            else check("idle_lines", {29'b0, busy, frame_done, tx}, 32'b001);
        end
    end

    initial begin
        #1 rst = 1'b0;
        #1 check("reset_state", {29'b0, tx, busy, frame_done}, 32'b100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        next_free = 0;
        repeat (2) @(negedge clk);

        // Known vector, then two ignored requests 50 clocks apart with different values
        pulse_send(12'h3C7, 1'b1, 1'b0);
        repeat (49) @(negedge clk);
        pulse_send(12'h111, 1'b0, 1'b1);
        repeat (49) @(negedge clk);
        pulse_send(12'hABC, 1'b1, 1'b1);

        // Request coincident with frame_done; ypos flips mid-frame
        wait_free(0);
        pulse_send(12'h000, 1'b0, 1'b0);
        check("b2b_start_next_cycle", {30'b0, busy, tx}, 32'b10);
        repeat (99) @(negedge clk);
        ypos = 12'hFFF;

        // Reset 137 clocks into a frame
        wait_free(0);
        repeat (5) @(negedge clk);
        pulse_send(12'h5A5, 1'b1, 1'b1);
        repeat (137) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1 check("async_abort", {29'b0, tx, busy, frame_done}, 32'b100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        next_free = 0;
        repeat (2) @(negedge clk);
        pulse_send(12'h9E2, 1'b0, 1'b1);

        // Random frames with input noise and ignored requests while busy
        for (int i = 0; i < 150; i++) begin
            wait_free(1);
            if ($urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(1, 20)) begin
                    rand_inputs();
                    @(negedge clk);
                end
            end
            pulse_send(12'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int c = 0; c < 2 * FRAME_CLKS && exp_q.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
